// File: rtl/ball_pair_scheduler.sv
// Ball-pair collision scheduler: snapshots ball state per frame, scans all pairs i<j and hands overlapping pairs to the resolver.
// Optional macro APPROACH_FILTER_EN: only closing (approaching) pairs are issued.
module ball_pair_scheduler #(
  parameter int unsigned NUM_BALLS     = 4,
  parameter int unsigned BALL_DIAMETER = 32
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_BALLS*11-1:0]     ballPosX,
  input  logic [NUM_BALLS*11-1:0]     ballPosY,
  input  logic [NUM_BALLS*11-1:0]     ballVelX,
  input  logic [NUM_BALLS*11-1:0]     ballVelY,
  output logic                        pairValid,
  input  logic                        pairReady,
  output logic [((NUM_BALLS > 2) ? $clog2(NUM_BALLS) : 1)-1:0] pairIdxA,
  output logic [((NUM_BALLS > 2) ? $clog2(NUM_BALLS) : 1)-1:0] pairIdxB,
  output logic                        busy,
  output logic                        frameDone,
  output logic [7:0]                  hitCount,
  output logic                        frameOverrun
);
  localparam int unsigned COORD_W = 11;
  localparam int unsigned DIFF_W  = 12;
  localparam int unsigned PROD_W  = 25;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned VEC_W   = NUM_BALLS * COORD_W;
  localparam int unsigned IDX_W   = (NUM_BALLS > 2) ? $clog2(NUM_BALLS) : 1;
  localparam logic [PROD_W-1:0] DIAM_SQ    = PROD_W'(BALL_DIAMETER * BALL_DIAMETER);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_BALLS - 1);
  localparam logic [IDX_W-1:0]  PENULT_IDX = IDX_W'(NUM_BALLS - 2);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ISSUE, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        pair_i, pair_j, pair_i_nxt, pair_j_nxt;
  logic [IDX_W-1:0]        adv_i_c, adv_j_c;
  logic                    last_pair_c;
  logic                    pair_valid_nxt, busy_nxt, frame_done_nxt, frame_overrun_nxt;
  logic [IDX_W-1:0]        idx_a_nxt, idx_b_nxt;
  logic [CNT_W-1:0]        hit_count_nxt;
  logic                    load_snap_c;
  logic [VEC_W-1:0]        snap_pos_x, snap_pos_y, snap_vel_x, snap_vel_y;

  // Per-ball views of the snapshot
  logic signed [COORD_W-1:0] pos_x [NUM_BALLS];
  logic signed [COORD_W-1:0] pos_y [NUM_BALLS];
  always_comb begin
    for (int k = 0; k < NUM_BALLS; k++) begin
      pos_x[k] = snap_pos_x[k*COORD_W +: COORD_W];
      pos_y[k] = snap_pos_y[k*COORD_W +: COORD_W];
    end
  end

  // Squared centre distance of the current pair
  logic signed [DIFF_W-1:0] dx_c, dy_c;
  logic signed [PROD_W-1:0] dx_w_c, dy_w_c, sq_x_c, sq_y_c;
  logic [PROD_W-1:0]        d2_c;
  logic                     overlap_c, hit_c;
  always_comb begin
    dx_c      = $signed({pos_x[pair_j][COORD_W-1], pos_x[pair_j]}) -
                $signed({pos_x[pair_i][COORD_W-1], pos_x[pair_i]});
    dy_c      = $signed({pos_y[pair_j][COORD_W-1], pos_y[pair_j]}) -
                $signed({pos_y[pair_i][COORD_W-1], pos_y[pair_i]});
    dx_w_c    = PROD_W'(dx_c);
    dy_w_c    = PROD_W'(dy_c);
    sq_x_c    = dx_w_c * dx_w_c;
    sq_y_c    = dy_w_c * dy_w_c;
    d2_c      = sq_x_c + sq_y_c;
    overlap_c = (d2_c != '0) && (d2_c < DIAM_SQ);
  end

`ifdef APPROACH_FILTER_EN
  logic signed [COORD_W-1:0] vel_x [NUM_BALLS];
  logic signed [COORD_W-1:0] vel_y [NUM_BALLS];
  logic signed [DIFF_W-1:0]  dvx_c, dvy_c;
  logic signed [PROD_W-1:0]  dot_c;
  always_comb begin
    for (int k = 0; k < NUM_BALLS; k++) begin
      vel_x[k] = snap_vel_x[k*COORD_W +: COORD_W];
      vel_y[k] = snap_vel_y[k*COORD_W +: COORD_W];
    end
    dvx_c = $signed({vel_x[pair_j][COORD_W-1], vel_x[pair_j]}) -
            $signed({vel_x[pair_i][COORD_W-1], vel_x[pair_i]});
    dvy_c = $signed({vel_y[pair_j][COORD_W-1], vel_y[pair_j]}) -
            $signed({vel_y[pair_i][COORD_W-1], vel_y[pair_i]});
    dot_c = dx_w_c * PROD_W'(dvx_c) + dy_w_c * PROD_W'(dvy_c);
    // Negative dot product means the centres are closing
    hit_c = overlap_c && dot_c[PROD_W-1];
  end
`else
  logic unused_vel_c;
  assign unused_vel_c = ^{snap_vel_x, snap_vel_y};
  assign hit_c        = overlap_c;
`endif

  // Next pair in (0,1)(0,2)..(N-2,N-1) order
  always_comb begin
    last_pair_c = (pair_i == PENULT_IDX) && (pair_j == LAST_IDX);
    if (pair_j < LAST_IDX) begin
      adv_i_c = pair_i;
      adv_j_c = pair_j + IDX_W'(1);
    end else begin
      adv_i_c = pair_i + IDX_W'(1);
      adv_j_c = pair_i + IDX_W'(2);
    end
  end

  always_comb begin
    state_nxt         = state;
    pair_i_nxt        = pair_i;
    pair_j_nxt        = pair_j;
    pair_valid_nxt    = pairValid;
    idx_a_nxt         = pairIdxA;
    idx_b_nxt         = pairIdxB;
    hit_count_nxt     = hitCount;
    frame_done_nxt    = 1'b0;
    frame_overrun_nxt = startOfFrame && (state != S_IDLE);
    load_snap_c       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (startOfFrame) begin
          load_snap_c   = 1'b1;
          pair_i_nxt    = '0;
          pair_j_nxt    = IDX_W'(1);
          hit_count_nxt = '0;
          state_nxt     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hit_c) begin
          idx_a_nxt      = pair_i;
          idx_b_nxt      = pair_j;
          pair_valid_nxt = 1'b1;
          if (hitCount != '1) hit_count_nxt = hitCount + CNT_W'(1);
          state_nxt      = S_ISSUE;
        end else if (last_pair_c) begin
          frame_done_nxt = 1'b1;
          state_nxt      = S_DONE;
        end else begin
          pair_i_nxt = adv_i_c;
          pair_j_nxt = adv_j_c;
        end
      end
      S_ISSUE: begin
        if (pairReady) begin
          pair_valid_nxt = 1'b0;
          if (last_pair_c) begin
            frame_done_nxt = 1'b1;
            state_nxt      = S_DONE;
          end else begin
            pair_i_nxt = adv_i_c;
            pair_j_nxt = adv_j_c;
            state_nxt  = S_CHECK;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= S_IDLE;
      pair_i       <= '0;
      pair_j       <= '0;
      pairValid    <= 1'b0;
      pairIdxA     <= '0;
      pairIdxB     <= '0;
      busy         <= 1'b0;
      frameDone    <= 1'b0;
      hitCount     <= '0;
      frameOverrun <= 1'b0;
      snap_pos_x   <= '0;
      snap_pos_y   <= '0;
      snap_vel_x   <= '0;
      snap_vel_y   <= '0;
    end else begin
      state        <= state_nxt;
      pair_i       <= pair_i_nxt;
      pair_j       <= pair_j_nxt;
      pairValid    <= pair_valid_nxt;
      pairIdxA     <= idx_a_nxt;
      pairIdxB     <= idx_b_nxt;
      busy         <= busy_nxt;
      frameDone    <= frame_done_nxt;
      hitCount     <= hit_count_nxt;
      frameOverrun <= frame_overrun_nxt;
      if (load_snap_c) begin
        snap_pos_x <= ballPosX;
        snap_pos_y <= ballPosY;
        snap_vel_x <= ballVelX;
        snap_vel_y <= ballVelY;
      end
    end
  end
endmodule

// File: tb/tb_ball_pair_scheduler.sv
// Directed self-checking bench for ball_pair_scheduler (NUM_BALLS=4, BALL_DIAMETER=32).
module tb_ball_pair_scheduler;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          resetN;
  logic          startOfFrame;
  logic [N*11-1:0] ballPosX, ballPosY, ballVelX, ballVelY;
  logic          pairValid, pairReady;
  logic [1:0]    pairIdxA, pairIdxB;
  logic          busy, frameDone, frameOverrun;
  logic [7:0]    hitCount;

  int errors = 0;
  int checks = 0;

  ball_pair_scheduler #(.NUM_BALLS(N), .BALL_DIAMETER(32)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .ballPosX(ballPosX), .ballPosY(ballPosY), .ballVelX(ballVelX), .ballVelY(ballVelY),
    .pairValid(pairValid), .pairReady(pairReady), .pairIdxA(pairIdxA), .pairIdxB(pairIdxB),
    .busy(busy), .frameDone(frameDone), .hitCount(hitCount), .frameOverrun(frameOverrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic place(input int k, input int x, input int y, input int vx, input int vy);
    ballPosX[k*11 +: 11] = 11'(x);
    ballPosY[k*11 +: 11] = 11'(y);
    ballVelX[k*11 +: 11] = 11'(vx);
    ballVelY[k*11 +: 11] = 11'(vy);
  endtask

  // One scan: edge index of frameDone (E0 = start edge), pairValid cycles, last pair indices,
  // index stability, overrun pulses seen, frameDone one cycle later.
  task automatic scan(input int low, input int ovr_at, output int done_edge, output int vcyc,
                      output int a, output int b, output int stable, output int ovr,
                      output int fd_after);
    int run;
    logic [N*11-1:0] close_x;
    close_x = {11'd15, 11'd10, 11'd5, 11'd0};
    done_edge = -1; vcyc = 0; a = -1; b = -1; stable = 1; ovr = 0; run = 0; fd_after = -1;
    @(posedge clk); #1; startOfFrame = 1'b1;
    @(posedge clk); #1; startOfFrame = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      startOfFrame = 1'b0;
      if (frameOverrun) ovr++;
      if (pairValid) begin
        if (run == 0) begin a = int'(pairIdxA); b = int'(pairIdxB); end
        else if (int'(pairIdxA) != a || int'(pairIdxB) != b) stable = 0;
        run++; vcyc++;
        pairReady = (run > low);
      end else begin
        run = 0; pairReady = 1'b0;
      end
      if (ovr_at == k) begin startOfFrame = 1'b1; ballPosX = close_x; end
      if (frameDone) begin done_edge = k; break; end
    end
    pairReady = 1'b0; startOfFrame = 1'b0;
    @(posedge clk); #1;
    fd_after = int'(frameDone);
  endtask

  int de, vc, pa, pb, st, ov, fa;

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; pairReady = 1'b0;
    ballPosX = '0; ballPosY = '0; ballVelX = '0; ballVelY = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", int'(pairValid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frameDone), 0);
    chk("rst_hits", int'(hitCount), 0);
    chk("rst_ovr", int'(frameOverrun), 0);
    chk("rst_idx", int'({pairIdxA, pairIdxB}), 0);
    resetN = 1'b1;

    // No overlap
    place(0, 0, 0, 0, 0); place(1, 100, 0, 0, 0); place(2, 200, 0, 0, 0); place(3, 300, 0, 0, 0);
    @(posedge clk); #1; startOfFrame = 1'b1;
    @(posedge clk); #1; startOfFrame = 1'b0;
    chk("busy_scan", int'(busy), 1);
    repeat (10) @(posedge clk); #1;
    chk("idle_after", int'(busy), 0);
    scan(0, -1, de, vc, pa, pb, st, ov, fa);
    chk("nohit_done", de, 6);
    chk("nohit_valid", vc, 0);
    chk("nohit_hits", int'(hitCount), 0);
    chk("nohit_fd1", fa, 0);

    // Single hit, ready immediately
    place(1, 20, 0, 0, 0); place(2, 200, 0, 0, 0); place(3, 400, 0, 0, 0);
    scan(0, -1, de, vc, pa, pb, st, ov, fa);
    chk("single_done", de, 7);
    chk("single_valid", vc, 1);
    chk("single_a", pa, 0);
    chk("single_b", pb, 1);
    chk("single_hits", int'(hitCount), 1);
    chk("single_fd1", fa, 0);
    chk("single_busy_after", int'(busy), 0);

    // Back-to-back start in the IDLE cycle after DONE, with backpressure
    scan(5, -1, de, vc, pa, pb, st, ov, fa);
    chk("bp_done", de, 12);
    chk("bp_valid", vc, 6);
    chk("bp_stable", st, 1);
    chk("bp_b", pb, 1);
    chk("bp_no_ovr", ov, 0);
    chk("bp_hits", int'(hitCount), 1);

    // Boundary: dx=32 misses, dx=-31 hits, coincident misses
    place(1, 32, 0, 0, 0);
    scan(0, -1, de, vc, pa, pb, st, ov, fa);
    chk("dx32_valid", vc, 0);
    chk("dx32_done", de, 6);
    place(1, -31, 0, 0, 0);
    scan(0, -1, de, vc, pa, pb, st, ov, fa);
    chk("dxm31_valid", vc, 1);
    chk("dxm31_hits", int'(hitCount), 1);
    place(1, 0, 0, 0, 0);
    scan(0, -1, de, vc, pa, pb, st, ov, fa);
    chk("same_valid", vc, 0);
    chk("same_hits", int'(hitCount), 0);

    // Diagonal overlap on pair (0,2): d2 = 100 + 400
    place(0, 100, 100, 0, 0); place(1, 300, 300, 0, 0); place(2, 110, 120, 0, 0); place(3, -300, -300, 0, 0);
    scan(0, -1, de, vc, pa, pb, st, ov, fa);
    chk("diag_a", pa, 0);
    chk("diag_b", pb, 2);
    chk("diag_done", de, 7);

    // Hit on the last pair, then straight to DONE
    place(0, 0, 0, 0, 0); place(1, 500, 0, 0, 0); place(2, 200, 0, 0, 0); place(3, 220, 0, 0, 0);
    scan(0, -1, de, vc, pa, pb, st, ov, fa);
    chk("last_a", pa, 2);
    chk("last_b", pb, 3);
    chk("last_done", de, 7);

    // Three hits: (0,1)(0,2)(1,2)
    place(0, 0, 0, 0, 0); place(1, 10, 0, 0, 0); place(2, 20, 0, 0, 0); place(3, 500, 0, 0, 0);
    scan(0, -1, de, vc, pa, pb, st, ov, fa);
    chk("multi_hits", int'(hitCount), 3);
    chk("multi_done", de, 9);
    chk("multi_a", pa, 1);
    chk("multi_b", pb, 2);

    // Overrun during CHECK; snapshot untouched despite input change
    place(0, 0, 0, 0, 0); place(1, 100, 0, 0, 0); place(2, 200, 0, 0, 0); place(3, 300, 0, 0, 0);
    scan(0, 2, de, vc, pa, pb, st, ov, fa);
    chk("ovr_pulses", ov, 1);
    chk("ovr_done", de, 6);
    chk("ovr_valid", vc, 0);

    // Approach filter
    place(0, 0, 0, 2, 0); place(1, 20, 0, -2, 0); place(2, 200, 0, 0, 0); place(3, 400, 0, 0, 0);
    scan(0, -1, de, vc, pa, pb, st, ov, fa);
    chk("approach_valid", vc, 1);
    place(1, 20, 0, 4, 0);
    scan(0, -1, de, vc, pa, pb, st, ov, fa);
`ifdef APPROACH_FILTER_EN
    chk("separate_valid", vc, 0);
`else
    chk("separate_valid", vc, 1);
`endif

    // Async reset while in ISSUE
    place(1, 20, 0, 0, 0);
    @(posedge clk); #1; startOfFrame = 1'b1;
    @(posedge clk); #1; startOfFrame = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", int'(pairValid), 1);
    repeat (2) @(posedge clk);
    #3; resetN = 1'b0; #1;
    chk("arst_valid", int'(pairValid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_hits", int'(hitCount), 0);
    chk("arst_idx", int'({pairIdxA, pairIdxB}), 0);
    @(posedge clk); #1; resetN = 1'b1;
    fa = 0;
    repeat (10) begin @(posedge clk); #1; if (frameDone) fa++; end
    chk("arst_no_done", fa, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
